// File: rtl/video_rect_pkg.sv
// Shared definitions for the rectangle capture/readout paths: coordinate width,
// FSM state encoding and the latched window record.
package video_rect_pkg;

  localparam int unsigned COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StCapture = 2'd2,
    StSkip    = 2'd3
  } wr_state_e;

  typedef struct packed {
    coord_t left;
    coord_t top;
    coord_t width;
    coord_t height;
  } rect_t;

  // Exclusive end coordinate, one bit wider so windows past the frame never wrap.
  function automatic logic [COORD_W:0] coord_end(coord_t base, coord_t size);
    return {1'b0, base} + {1'b0, size};
  endfunction

endpackage

// File: rtl/video_rect_write_data_if.sv
// Frame-buffer write port: start-of-frame request/ack, pixel strobe and status pulses.
interface video_rect_write_data_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  write_req;
  logic                  write_req_ack;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  frame_done;
  logic                  frame_skip;

  modport master (
    output write_req,
    input  write_req_ack,
    output write_en,
    output write_data,
    output frame_done,
    output frame_skip
  );

  modport slave (
    input  write_req,
    output write_req_ack,
    input  write_en,
    input  write_data,
    input  frame_done,
    input  frame_skip
  );
endinterface

// File: rtl/video_xy_counter.sv
// DE-driven pixel/line counters plus vertical-sync falling-edge detect.
module video_xy_counter
  import video_rect_pkg::*;
(
  input  logic   video_clk,
  input  logic   rst,
  input  logic   vin_vs,
  input  logic   vin_de,
  output coord_t x,
  output coord_t y,
  output logic   frame_start
);

  logic   vs_q;
  logic   de_q;
  coord_t x_q;
  coord_t y_q;

  assign frame_start = vs_q & ~vin_vs;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vs_q <= vin_vs;
      de_q <= vin_de;
      x_q  <= vin_de ? x_q + coord_t'(1) : '0;
      // Boundary clear wins over a coincident DE falling edge.
      if (frame_start) begin
        y_q <= '0;
      end else if (de_q && !vin_de) begin
        y_q <= y_q + coord_t'(1);
      end
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/video_rect_write_data.sv
// Captures a boundary-latched window of the input stream and streams its pixels,
// raster order, into the frame-buffer write port after a per-frame request/ack.
module video_rect_write_data
  import video_rect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  coord_t                video_left_offset,
  input  coord_t                video_top_offset,
  input  coord_t                video_width,
  input  coord_t                video_height,
  input  logic                  vin_hs,
  input  logic                  vin_vs,
  input  logic                  vin_de,
  input  logic [DATA_WIDTH-1:0] vin_data,
  video_rect_write_data_if.master wr
);

  coord_t x;
  coord_t y;
  logic   frame_start;

  video_xy_counter u_xy_counter (
    .video_clk   (video_clk),
    .rst         (rst),
    .vin_vs      (vin_vs),
    .vin_de      (vin_de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  logic unused_hs;
  assign unused_hs = vin_hs;

  rect_t win_q;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (frame_start) begin
      win_q <= '{left: video_left_offset, top: video_top_offset,
                 width: video_width, height: video_height};
    end
  end

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             hit;
  logic             last;
  logic             win_empty;

  assign x_end     = coord_end(win_q.left, win_q.width);
  assign y_end     = coord_end(win_q.top, win_q.height);
  assign hit       = vin_de && (x >= win_q.left) && ({1'b0, x} < x_end) &&
                     (y >= win_q.top) && ({1'b0, y} < y_end);
  assign last      = ({1'b0, x} == x_end - 13'd1) && ({1'b0, y} == y_end - 13'd1);
  assign win_empty = (video_width == '0) || (video_height == '0);

  wr_state_e             state_q, state_d;
  logic                  write_req_q, write_req_d;
  logic                  write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_skip_q, frame_skip_d;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      write_req_q  <= 1'b0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_skip_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_req_q  <= write_req_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      frame_done_q <= frame_done_d;
      frame_skip_q <= frame_skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = win_empty ? StIdle : StReq;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        // A one-pixel window can complete on the very edge that accepts the ack.
        StReq: begin
          if (wr.write_req_ack) begin
            state_d = (hit && last) ? StIdle : StCapture;
          end else if (hit) begin
            state_d = StSkip;
          end
        end
        StCapture: if (hit && last) state_d = StIdle;
        StSkip:    state_d = StSkip;
      endcase
    end
  end

  logic capture_ok;
  assign capture_ok = (state_q == StCapture) || ((state_q == StReq) && wr.write_req_ack);

  always_comb begin
    write_req_d  = 1'b0;
    write_en_d   = 1'b0;
    write_data_d = write_data_q;
    frame_done_d = 1'b0;
    frame_skip_d = 1'b0;
    if (frame_start) begin
      write_req_d = !win_empty;
    end else begin
      if (capture_ok && hit) begin
        write_en_d   = 1'b1;
        write_data_d = vin_data;
        frame_done_d = last;
      end
      if ((state_q == StReq) && !wr.write_req_ack) begin
        if (hit) frame_skip_d = 1'b1;
        else     write_req_d  = 1'b1;
      end
    end
  end

  assign wr.write_req  = write_req_q;
  assign wr.write_en   = write_en_q;
  assign wr.write_data = write_data_q;
  assign wr.frame_done = frame_done_q;
  assign wr.frame_skip = frame_skip_q;

endmodule

// File: tb/tb_video_rect_write_data.sv
// Self-checking bench: synthetic 64x8 frames, expected window pixels queued at drive time.
module tb_video_rect_write_data;

  localparam int H_ACT = 64;
  localparam int V_ACT = 8;
  localparam int HBP   = 4;
  localparam int LINE  = 72;
  localparam int VBP   = 4;
  localparam int FRAME_CYC = VBP + V_ACT * LINE + 4;

  logic        video_clk = 1'b0;
  logic        rst;
  logic [11:0] video_left_offset, video_top_offset, video_width, video_height;
  logic        vin_hs, vin_vs, vin_de;
  logic [15:0] vin_data;

  video_rect_write_data_if #(.DATA_WIDTH(16)) wif ();

  video_rect_write_data #(.DATA_WIDTH(16)) dut (
    .video_clk         (video_clk),
    .rst               (rst),
    .video_left_offset (video_left_offset),
    .video_top_offset  (video_top_offset),
    .video_width       (video_width),
    .video_height      (video_height),
    .vin_hs            (vin_hs),
    .vin_vs            (vin_vs),
    .vin_de            (vin_de),
    .vin_data          (vin_data),
    .wr                (wif)
  );

  always #5 video_clk = ~video_clk;

  typedef struct {
    logic [15:0] data;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          wr_cnt = 0, done_cnt = 0, skip_cnt = 0, req_rise = 0;
  int          skip_cyc = -1, first_hit_cyc = -1;
  logic        req_prev = 1'b0;
  logic [15:0] last_wd = '0;
  bit          exp_on = 1'b0;
  int          win_l, win_t, win_w, win_h, seed = 0;

  always @(posedge video_clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the next queued pixel; otherwise outputs hold.
  always @(negedge video_clk) begin
    if (!rst) begin
      n_vec++;
      if (wif.write_en === 1'b1) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got write_en=1 data=%h, required write_en=0",
                   wif.write_data);
        end else begin
          e = sb.pop_front();
          if (wif.write_data !== e.data || wif.frame_done !== e.last) begin
            n_err++;
            $display("FAIL write_pixel: got data=%h done=%b, required data=%h done=%b",
                     wif.write_data, wif.frame_done, e.data, e.last);
          end
          last_wd = e.data;
        end
      end else if (wif.write_en !== 1'b0 || wif.frame_done !== 1'b0 ||
                   wif.write_data !== last_wd) begin
        n_err++;
        $display("FAIL idle_hold: got en=%b done=%b data=%h, required en=0 done=0 data=%h",
                 wif.write_en, wif.frame_done, wif.write_data, last_wd);
      end
      if (wif.frame_done === 1'b1) done_cnt++;
      if (wif.frame_skip === 1'b1) begin
        skip_cnt++;
        skip_cyc = cyc;
      end
      if (wif.write_req === 1'b1 && req_prev === 1'b0) req_rise++;
      req_prev = wif.write_req;
    end
  end

  task automatic set_window(input int l, input int t, input int w, input int h);
    win_l = l; win_t = t; win_w = w; win_h = h;
  endtask

  // ack_cyc: cycle index after the boundary cycle (c=0) carrying a one-cycle ack.
  task automatic drive_frame(input int ack_cyc, input bit capture, input int rst_cyc,
                             input bit scramble);
    seed++;
    video_left_offset = 12'(win_l);
    video_top_offset  = 12'(win_t);
    video_width       = 12'(win_w);
    video_height      = 12'(win_h);
    for (int i = 0; i < 3; i++) begin
      @(posedge video_clk); #1;
      vin_vs = 1'b1; vin_hs = 1'b1; vin_de = 1'b0; wif.write_req_ack = 1'b0;
      vin_data = 16'($urandom);
    end
    exp_on = capture;
    first_hit_cyc = -1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      int  ln, yy, pos, xx;
      bit  de, inwin;
      @(posedge video_clk); #1;
      vin_vs = 1'b0;
      wif.write_req_ack = (c == ack_cyc);
      if (scramble && c == 50) begin
        video_left_offset = 12'($urandom); video_top_offset = 12'($urandom);
        video_width = 12'($urandom);       video_height = 12'($urandom);
      end
      if (c == rst_cyc) begin
        rst = 1'b1; exp_on = 1'b0; sb.delete(); last_wd = '0;
        #1;
        n_vec++;
        if ({wif.write_req, wif.write_en, wif.write_data, wif.frame_done, wif.frame_skip}
            !== 20'd0) begin
          n_err++;
          $display("FAIL reset_mid_frame: got req=%b en=%b data=%h done=%b skip=%b, required all 0",
                   wif.write_req, wif.write_en, wif.write_data, wif.frame_done, wif.frame_skip);
        end
      end
      if (rst_cyc >= 0 && c == rst_cyc + 2) rst = 1'b0;
      ln  = c - VBP;
      yy  = (ln >= 0) ? ln / LINE : -1;
      pos = (ln >= 0) ? ln % LINE : 0;
      xx  = pos - HBP;
      de  = (yy >= 0) && (yy < V_ACT) && (xx >= 0) && (xx < H_ACT);
      vin_hs = (pos >= LINE - 2);
      vin_de = de;
      vin_data = de ? {4'(seed), 6'(yy), 6'(xx)} : 16'($urandom);
      inwin = de && xx >= win_l && xx < win_l + win_w && yy >= win_t && yy < win_t + win_h;
      if (inwin) begin
        if (first_hit_cyc < 0) first_hit_cyc = cyc;
        if (exp_on) sb.push_back('{data: vin_data,
                                    last: (xx == win_l + win_w - 1) && (yy == win_t + win_h - 1)});
      end
    end
  endtask

  task automatic check_counts(input string name, input int wr0, input int dn0, input int sk0,
                              input int rq0, input int ewr, input int edn, input int esk,
                              input int erq);
    n_vec++;
    if (wr_cnt - wr0 != ewr || done_cnt - dn0 != edn || skip_cnt - sk0 != esk ||
        req_rise - rq0 != erq || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: got writes=%0d done=%0d skip=%0d req=%0d pending=%0d, required %0d/%0d/%0d/%0d/0",
               name, wr_cnt - wr0, done_cnt - dn0, skip_cnt - sk0, req_rise - rq0, sb.size(),
               ewr, edn, esk, erq);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    vin_vs = 1'b0; vin_hs = 1'b0; vin_de = 1'b0; vin_data = '0; wif.write_req_ack = 1'b0;
    video_left_offset = '0; video_top_offset = '0; video_width = '0; video_height = '0;
    repeat (3) @(posedge video_clk);
    @(negedge video_clk);
    n_vec++;
    if (wif.write_req !== 1'b0 || wif.write_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_en: got req=%b en=%b, required 0 0", wif.write_req, wif.write_en);
    end
    n_vec++;
    if (wif.write_data !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 0000", wif.write_data);
    end
    n_vec++;
    if (wif.frame_done !== 1'b0 || wif.frame_skip !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got done=%b skip=%b, required 0 0",
               wif.frame_done, wif.frame_skip);
    end
    @(posedge video_clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge video_clk);
  endtask

  task automatic test_basic;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(10, 2, 4, 3);
    drive_frame(5, 1'b1, -1, 1'b1);
    check_counts("basic_capture", wr0, dn0, sk0, rq0, 12, 1, 0, 1);
  endtask

  task automatic test_late_ack;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(10, 2, 4, 3);
    drive_frame(170, 1'b0, -1, 1'b0);
    check_counts("late_ack_skip", wr0, dn0, sk0, rq0, 0, 0, 1, 1);
    n_vec++;
    if (skip_cyc != first_hit_cyc + 1) begin
      n_err++;
      $display("FAIL skip_timing: got skip at cycle %0d, required %0d",
               skip_cyc, first_hit_cyc + 1);
    end
    wr0 = wr_cnt; dn0 = done_cnt; sk0 = skip_cnt; rq0 = req_rise;
    drive_frame(5, 1'b1, -1, 1'b0);
    check_counts("after_skip_capture", wr0, dn0, sk0, rq0, 12, 1, 0, 1);
  endtask

  task automatic test_ack_same_cycle;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(10, 2, 4, 3);
    // First window pixel (10,2) is driven at c = VBP + 2*LINE + HBP + 10.
    drive_frame(VBP + 2 * LINE + HBP + 10, 1'b1, -1, 1'b0);
    check_counts("ack_on_first_pixel", wr0, dn0, sk0, rq0, 12, 1, 0, 1);
  endtask

  task automatic test_zero_width;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(10, 2, 0, 3);
    drive_frame(5, 1'b1, -1, 1'b0);
    check_counts("zero_width", wr0, dn0, sk0, rq0, 0, 0, 0, 0);
  endtask

  task automatic test_clip;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(60, 2, 10, 3);
    drive_frame(5, 1'b1, -1, 1'b0);
    check_counts("clipped_window", wr0, dn0, sk0, rq0, 12, 0, 0, 1);
    wr0 = wr_cnt; dn0 = done_cnt; sk0 = skip_cnt; rq0 = req_rise;
    set_window(0, 5, 3, 2);
    drive_frame(7, 1'b1, -1, 1'b0);
    check_counts("after_clip_capture", wr0, dn0, sk0, rq0, 6, 1, 0, 1);
  endtask

  task automatic test_reset_mid_capture;
    int wr0 = wr_cnt, dn0 = done_cnt, sk0 = skip_cnt, rq0 = req_rise;
    set_window(10, 2, 4, 3);
    // Reset lands mid line 3: only the four line-2 pixels reach the output.
    drive_frame(5, 1'b1, VBP + 3 * LINE + HBP + 11, 1'b0);
    check_counts("reset_mid_capture", wr0, dn0, sk0, rq0, 4, 0, 0, 1);
    wr0 = wr_cnt; dn0 = done_cnt; sk0 = skip_cnt; rq0 = req_rise;
    drive_frame(9, 1'b1, -1, 1'b0);
    check_counts("after_reset_capture", wr0, dn0, sk0, rq0, 12, 1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_late_ack();
    test_ack_same_cycle();
    test_zero_width();
    test_clip();
    test_reset_mid_capture();
    repeat (4) @(posedge video_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_rect_write_data.md
# video_rect_write_data

Captures a rectangular window from an incoming video stream and pushes its pixels, raster order, into a frame-buffer write FIFO. Per frame it issues a write request at the frame boundary, waits for the buffer controller's acknowledge, then emits one write strobe per in-window active pixel. It is the capture-side counterpart of the rectangle readout path and sits between the video input timing and the frame-buffer write port.

## Interface
- DATA_WIDTH, 16, bits per pixel on vin_data / write_data
- video_clk  in  1  pixel clock
- rst  in  1  reset rst, asynchronous, active-high; clock video_clk
- video_left_offset  in  12  window left column, sampled at frame boundary
- video_top_offset  in  12  window top line, sampled at frame boundary
- video_width  in  12  window width in pixels, sampled at frame boundary
- video_height  in  12  window height in lines, sampled at frame boundary
- vin_hs  in  1  input horizontal sync (unused for counting, passed to no output)
- vin_vs  in  1  input vertical sync, active-high pulse
- vin_de  in  1  input active-video enable
- vin_data  in  DATA_WIDTH  input pixel
- write_req  out  1  start-of-frame write request to buffer controller
- write_req_ack  in  1  request accepted
- write_en  out  1  write strobe, one per captured pixel
- write_data  out  DATA_WIDTH  pixel to write
- frame_done  out  1  one-cycle pulse after last window pixel written
- frame_skip  out  1  one-cycle pulse when a frame is abandoned for late ack

## Operation
- Coordinates: x = index of current vin_de=1 pixel within line (0 at first DE cycle, cleared while vin_de=0); y = active-line index (increments on vin_de falling edge, cleared at frame boundary).
- Frame boundary: edge sampling vin_vs=0 with previous sample 1.
- Window hit: vin_de & x ≥ left & x < left+width & y ≥ top & y < top+height; sums computed 13-bit, no wrap; windows extending past the frame are clipped naturally.
- States: IDLE, REQ, CAPTURE, SKIP.
- Any state, frame boundary: latch offsets/sizes; if width=0 or height=0 go IDLE with write_req=0; else write_req←1, go REQ. Ack sampled on the boundary edge is ignored.
- REQ, ack=1: write_req←0, go CAPTURE; a window pixel sampled on this same edge is written.
- REQ, ack=0, window hit: write_req←0, frame_skip pulse, go SKIP; no writes until next boundary.
- CAPTURE: write_en←hit, write_data←vin_data when hit. Hit at x=left+width−1, y=top+height−1: frame_done pulse, go IDLE.
- Frame boundary during CAPTURE (truncated frame): no frame_done; restart as above.
- write_data holds last written value when write_en=0.

## Timing
- Reset: write_req=0, write_en=0, write_data=0, frame_done=0, frame_skip=0, state IDLE, counters 0, latched window 0.
- write_req rises on the boundary edge; stays high until edge sampling ack=1 or skip.
- Pixel latency: write_en/write_data registered, 1 cycle after vin_de/vin_data sampled.
- frame_done coincides with the last write_en cycle; frame_skip asserts 1 cycle after the missed pixel is sampled.
- Window inputs may change anytime; only boundary-latched values are used.
- rst mid-frame: all outputs to reset values immediately; capture resumes only after next boundary.

## Structure
- Package video_rect_pkg: COORD_W=12, state encoding constants (IDLE/REQ/CAPTURE/SKIP), shared with readout side.
- Sub-module video_xy_counter: de-driven x/y counters and vs edge detect, outputs x, y, frame_start.
- Top: window latch, hit compare, FSM, output registers.

## Test plan
- 64×8 frame, window left=10 top=2 w=4 h=3, ack 5 cycles after req -> exactly 12 write_en, data = pixels (10..13, 2..4), frame_done on 12th.
- Ack withheld until after first window pixel -> frame_skip pulse, 0 writes, next frame captures normally.
- Ack on same cycle as first window pixel -> that pixel written, 12 writes total.
- width=0 -> write_req never asserts, no writes, no frame_done.
- Window left=60 w=10 on 64-wide frame -> 4 writes per line, no frame_done; next boundary restarts cleanly.
- rst asserted mid-CAPTURE -> all outputs 0 next edge; after release, first write only after following vs falling edge and ack.
